rr_decode_arbiter: RTL and testbench
====================================

Name: rr_decode_arbiter

Overview:
- Round-robin arbiter that shares one 8-way resource among 8 requesters.
- Selects a winner index and drives a one-hot grant through an internal 3:8 shift decoder.
- Sits in front of the decoder-driven select/enable fabric, so that only one consumer is enabled per cycle.
- Grants are registered and held while the owner keeps requesting, with an optional hold timeout for fairness.

Parameters:
- MAX_HOLD, 15, maximum consecutive grant cycles per owner when the timeout feature is compiled in; legal range 1..255.
- N_REQ, 8, number of requesters; fixed to 8 to match the 3-bit decoder select; not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- EN  input  1  arbiter enable; low blocks new grants and revokes the current grant
- req  input  8  request vector, bit i = requester i
- grant  output  8  registered one-hot grant, all zeros when idle
- gnt_idx  output  3  binary index of the current owner, valid when gnt_valid=1
- gnt_valid  output  1  high when grant is non-zero

Behaviour:
- Reset (rst_n=0, asynchronous) sets:
  - grant=8'h00, gnt_idx=3'd0, gnt_valid=0
  - state=IDLE, priority pointer ptr=3'd0, hold counter=0
- States:
  - IDLE: no owner.
  - BUSY: owner held in gnt_idx.
- IDLE -> BUSY:
  - Taken when EN=1 and req!=0.
  - Winner is the first set bit of req, scanning ptr, ptr+1, ..., ptr+7 modulo 8 (3-bit wrap, 7 wraps to 0).
  - On the same edge, gnt_idx<=winner and grant<=8'b1<<winner.
  - Latency: req sampled at edge t gives grant visible after edge t.
- BUSY, hold:
  - While EN=1 and req[gnt_idx]=1 (and no timeout), grant is unchanged.
  - Other requests are ignored.
- BUSY, release:
  - Triggered when req[gnt_idx]=0 at a sampling edge.
  - ptr<=gnt_idx+1 (mod 8).
  - If any other req bit is set on that edge, grant moves directly to the next winner on the same edge (no idle bubble). The scan starts from gnt_idx+1, and the releasing owner's bit is excluded.
  - Otherwise go to IDLE with grant=0.
- EN=0 in any state:
  - On the next edge, grant=0, gnt_valid=0, state=IDLE.
  - ptr is unchanged, so the revoked owner keeps top priority when EN returns.
- Hold counter:
  - Cleared on every new grant.
  - Increments each BUSY cycle while held; saturates at MAX_HOLD.
  - Width is $clog2(MAX_HOLD+1).
- Invariants:
  - grant is always zero or exactly one-hot.
  - gnt_valid == (grant!=0).
  - grant == decoder(gnt_idx) whenever gnt_valid=1.
- Simultaneous requests: resolved purely by ptr order, with no fixed priority.
- Reset mid-grant: outputs clear immediately (asynchronously), with no wait for clk.

Optional Feature:
- Macro: RR_HOLD_TIMEOUT_EN.
- Defined:
  - When the hold counter reaches MAX_HOLD and any other req bit is set, the owner is forcibly released on that edge.
  - ptr<=gnt_idx+1 and the next winner is granted on the same edge.
  - If no other requester is pending, the owner keeps the grant and the counter stays saturated.
- Undefined:
  - No counter logic is present.
  - The owner holds the grant indefinitely while its req stays high.

Decomposition:
- Package rr_arb_pkg holds:
  - state enum arb_state_t {IDLE, BUSY}
  - localparam N_REQ=8
  - localparam IDX_W=3
  - the ptr-rotated first-one search function
- One natural sub-module: a 3:8 shift decoder, instantiated as the grant generator.
  - Inputs: EN, s=next_idx.
  - Output: q, registered by the arbiter.

Test Plan:
- Reset then single request: rst_n 0->1, EN=1, req=8'h04 -> one edge later grant=8'h04, gnt_idx=2, gnt_valid=1.
- Round-robin rotation: req=8'hFF held, each owner drops its bit for one cycle in turn -> grants advance 0x01, 0x02, 0x04 ... 0x80, 0x01 with no idle cycles, including the 7->0 wrap.
- Back-to-back handoff: owner 5, req changes 8'h20 -> 8'h03 -> next edge grant=8'h01 and ptr=6 before the choice. Then req=8'h02 -> grant=8'h02.
- EN revoke: owner 3 active, EN=0 for 2 cycles -> grant=0 after the next edge. EN=1 with req=8'h18 -> grant=8'h08, because ptr is still 3.
- Async reset mid-grant: rst_n pulsed low between clock edges while grant=8'h40 -> grant=0 and gnt_valid=0 immediately, with no clk edge.
- Timeout (RR_HOLD_TIMEOUT_EN, MAX_HOLD=4): req=8'h81 held, owner 0 -> after 4 held cycles grant moves to 8'h80. Same test with only req=8'h01 -> grant stays 8'h01.

Source files
------------

// File: rtl/rr_decode_arbiter_pkg.sv
// Shared types, sizes and the rotating first-one search for the round-robin decode arbiter.
package rr_arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Index of the first set bit of vec, scanning start, start+1, ... with 3-bit wrap.
  // Callers only use the result when vec is non-zero.
  function automatic logic [IDX_W-1:0] rr_first(input logic [N_REQ-1:0] vec,
                                                input logic [IDX_W-1:0] start);
    logic [IDX_W-1:0] idx;
    logic             found;
    rr_first = start;
    found    = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = start + IDX_W'(i);
      if (!found && vec[idx]) begin
        rr_first = idx;
        found    = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/rr_decode_arbiter_decoder.sv
// 3:8 shift decoder producing the one-hot grant pattern for the arbiter.
module rr_decode_arbiter_decoder
  import rr_arb_pkg::*;
(
  input  logic             EN,
  input  logic [IDX_W-1:0] s,
  output logic [N_REQ-1:0] q
);

  assign q = EN ? (N_REQ'(1) << s) : '0;

endmodule

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter over 8 requesters with a registered one-hot grant.
// Optional owner hold timeout is compiled in with `define RR_HOLD_TIMEOUT_EN.
module rr_decode_arbiter
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             EN,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_max_hold_range
    $error("rr_decode_arbiter: MAX_HOLD must be within 1..255");
  end

  arb_state_t       state_q, next_state;
  logic [IDX_W-1:0] ptr_q, next_ptr;
  logic [IDX_W-1:0] gnt_idx_q, next_idx;
  logic [N_REQ-1:0] grant_q, dec_q;
  logic             next_valid;
  logic [N_REQ-1:0] others;
  logic             hold_timeout;
  logic             owner_release;

  assign others        = req & ~(N_REQ'(1) << gnt_idx_q);
  assign owner_release = (state_q == BUSY) && (!req[gnt_idx_q] || hold_timeout);

`ifdef RR_HOLD_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  logic [HOLD_W-1:0] hold_cnt_q;

  assign hold_timeout = (hold_cnt_q == HOLD_MAX) && (|others);

  // Counts consecutive held cycles of the current owner; any new grant or idle restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
    end else if (!next_valid || state_q == IDLE || owner_release) begin
      hold_cnt_q <= '0;
    end else if (hold_cnt_q != HOLD_MAX) begin
      hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
    end
  end
`else
  assign hold_timeout = 1'b0;
`endif

  always_comb begin
    next_state = state_q;
    next_ptr   = ptr_q;
    next_idx   = gnt_idx_q;
    next_valid = 1'b0;
    if (!EN) begin
      next_state = IDLE;
    end else if (state_q == IDLE) begin
      if (|req) begin
        next_idx   = rr_first(req, ptr_q);
        next_valid = 1'b1;
        next_state = BUSY;
      end
    end else if (owner_release) begin
      // Hand off on the same edge, scanning just past the departing owner.
      next_ptr = gnt_idx_q + IDX_W'(1);
      if (|others) begin
        next_idx   = rr_first(others, gnt_idx_q + IDX_W'(1));
        next_valid = 1'b1;
      end else begin
        next_state = IDLE;
      end
    end else begin
      next_valid = 1'b1;
    end
  end

  rr_decode_arbiter_decoder u_grant_dec (
    .EN (next_valid),
    .s  (next_idx),
    .q  (dec_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_idx_q <= '0;
      grant_q   <= '0;
    end else begin
      state_q   <= next_state;
      ptr_q     <= next_ptr;
      gnt_idx_q <= next_idx;
      grant_q   <= dec_q;
    end
  end

  assign grant     = grant_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = |grant_q;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Directed self-checking bench for rr_decode_arbiter (built with MAX_HOLD=4).
module tb_rr_decode_arbiter;

  logic       clk;
  logic       rst_n;
  logic       EN;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] gnt_idx;
  logic       gnt_valid;

  int vectors;
  int miscompares;

  rr_decode_arbiter #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .EN        (EN),
    .req       (req),
    .grant     (grant),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    EN    = 1'b0;
    req   = 8'h00;
    #12;
    vectors++;
    if ({grant, gnt_idx, gnt_valid} !== {8'h00, 3'd0, 1'b0}) begin
      $display("[TB] FAIL reset: grant=%h idx=%0d valid=%b, want 00/0/0", grant, gnt_idx, gnt_valid);
      miscompares++;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    EN  = 1'b1;
    req = 8'h04;
    tick();
    vectors++;
    if ({grant, gnt_idx, gnt_valid} !== {8'h04, 3'd2, 1'b1}) begin
      $display("[TB] FAIL single: grant=%h idx=%0d valid=%b, want 04/2/1", grant, gnt_idx, gnt_valid);
      miscompares++;
    end
    req = 8'h00;
    tick();
    vectors++;
    if ({grant, gnt_valid} !== {8'h00, 1'b0}) begin
      $display("[TB] FAIL single_idle: grant=%h valid=%b, want 00/0", grant, gnt_valid);
      miscompares++;
    end
  endtask

  task automatic test_rotation();
    logic [7:0] exp_grant;
    req = 8'h01;
    tick();
    vectors++;
    if ({grant, gnt_idx, gnt_valid} !== {8'h01, 3'd0, 1'b1}) begin
      $display("[TB] FAIL rot_start: grant=%h idx=%0d valid=%b, want 01/0/1", grant, gnt_idx, gnt_valid);
      miscompares++;
    end
    req = 8'hFF;
    tick();
    for (int k = 0; k < 8; k++) begin
      req = 8'hFF & ~(8'h01 << k);
      tick();
      exp_grant = 8'h01 << ((k + 1) % 8);
      vectors++;
      if ({grant, gnt_idx, gnt_valid} !== {exp_grant, 3'((k + 1) % 8), 1'b1}) begin
        $display("[TB] FAIL rot_step%0d: grant=%h idx=%0d valid=%b, want %h/%0d/1",
                 k, grant, gnt_idx, gnt_valid, exp_grant, (k + 1) % 8);
        miscompares++;
      end
      req = 8'hFF;
      tick();
      vectors++;
      if (grant !== exp_grant) begin
        $display("[TB] FAIL rot_hold%0d: grant=%h, want %h", k, grant, exp_grant);
        miscompares++;
      end
    end
    req = 8'h00;
    tick();
  endtask

  task automatic test_back_to_back();
    req = 8'h20;
    tick();
    vectors++;
    if ({grant, gnt_idx} !== {8'h20, 3'd5}) begin
      $display("[TB] FAIL b2b_owner5: grant=%h idx=%0d, want 20/5", grant, gnt_idx);
      miscompares++;
    end
    req = 8'h03;
    tick();
    vectors++;
    if ({grant, gnt_idx, gnt_valid} !== {8'h01, 3'd0, 1'b1}) begin
      $display("[TB] FAIL b2b_handoff: grant=%h idx=%0d valid=%b, want 01/0/1", grant, gnt_idx, gnt_valid);
      miscompares++;
    end
    req = 8'h02;
    tick();
    vectors++;
    if ({grant, gnt_idx} !== {8'h02, 3'd1}) begin
      $display("[TB] FAIL b2b_second: grant=%h idx=%0d, want 02/1", grant, gnt_idx);
      miscompares++;
    end
    req = 8'h00;
    tick();
  endtask

  task automatic test_en_revoke();
    req = 8'h04;
    tick();
    req = 8'h08;
    tick();
    vectors++;
    if ({grant, gnt_idx} !== {8'h08, 3'd3}) begin
      $display("[TB] FAIL revoke_owner3: grant=%h idx=%0d, want 08/3", grant, gnt_idx);
      miscompares++;
    end
    EN = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      vectors++;
      if ({grant, gnt_valid} !== {8'h00, 1'b0}) begin
        $display("[TB] FAIL revoke_off%0d: grant=%h valid=%b, want 00/0", c, grant, gnt_valid);
        miscompares++;
      end
    end
    EN  = 1'b1;
    req = 8'h18;
    tick();
    vectors++;
    if ({grant, gnt_idx, gnt_valid} !== {8'h08, 3'd3, 1'b1}) begin
      $display("[TB] FAIL revoke_return: grant=%h idx=%0d valid=%b, want 08/3/1", grant, gnt_idx, gnt_valid);
      miscompares++;
    end
    req = 8'h00;
    tick();
  endtask

  task automatic test_async_reset();
    req = 8'h40;
    tick();
    vectors++;
    if (grant !== 8'h40) begin
      $display("[TB] FAIL areset_pre: grant=%h, want 40", grant);
      miscompares++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({grant, gnt_valid} !== {8'h00, 1'b0}) begin
      $display("[TB] FAIL areset_mid: grant=%h valid=%b, want 00/0", grant, gnt_valid);
      miscompares++;
    end
    req = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_timeout();
    req = 8'h81;
    tick();
    vectors++;
    if (grant !== 8'h01) begin
      $display("[TB] FAIL timeout_start: grant=%h, want 01", grant);
      miscompares++;
    end
    for (int c = 1; c <= 4; c++) begin
      tick();
      vectors++;
      if (grant !== 8'h01) begin
        $display("[TB] FAIL timeout_held%0d: grant=%h, want 01", c, grant);
        miscompares++;
      end
    end
    tick();
`ifdef RR_HOLD_TIMEOUT_EN
    vectors++;
    if ({grant, gnt_idx} !== {8'h80, 3'd7}) begin
      $display("[TB] FAIL timeout_move: grant=%h idx=%0d, want 80/7", grant, gnt_idx);
      miscompares++;
    end
`else
    vectors++;
    if (grant !== 8'h01) begin
      $display("[TB] FAIL no_timeout_hold: grant=%h, want 01", grant);
      miscompares++;
    end
`endif
    req = 8'h00;
    tick();
    req = 8'h01;
    for (int c = 0; c < 8; c++) begin
      tick();
      vectors++;
      if ({grant, gnt_idx, gnt_valid} !== {8'h01, 3'd0, 1'b1}) begin
        $display("[TB] FAIL timeout_alone%0d: grant=%h idx=%0d valid=%b, want 01/0/1", c, grant, gnt_idx, gnt_valid);
        miscompares++;
      end
    end
    req = 8'h00;
    tick();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_single();
    test_rotation();
    test_back_to_back();
    test_en_revoke();
    test_async_reset();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
